// File: rtl/lb_ctrl_pkg.sv
// rtl/lb_ctrl_pkg.sv - shared types and width helpers for the linebuffer stream controller
//
// Purpose: FSM state encoding and counter-width helper used by the controller
// and its coordinate counter.
// Ports: none (package).

package lb_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARMUP = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } lb_state_e;

  // Counter width for a dimension of n pixels; at least one bit.
  function automatic int lb_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lb_coord_counter.sv
// rtl/lb_coord_counter.sv - raster-order column/row counter for one frame
//
// Purpose: tracks the coordinates of the next pixel to be accepted.
// Ports:
//   clk     in   clock
//   rst_n   in   synchronous active-low reset
//   clr_i   in   restart at (0,0)
//   en_i    in   advance one pixel
//   col_o   out  current column
//   row_o   out  current row
//   last_o  out  current position is the final pixel of the frame

module lb_coord_counter
  import lb_ctrl_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int CW    = lb_width(IMG_W),
  parameter int RW    = lb_width(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          last_o
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          col_end;

  assign col_end = (col_q == COL_LAST);
  assign last_o  = col_end && (row_q == ROW_LAST);
  assign col_o   = col_q;
  assign row_o   = row_q;

  // The final pixel does not wrap: the counter parks there until cleared.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i && !last_o) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/linebuffer_stream_ctrl.sv
// rtl/linebuffer_stream_ctrl.sv - frame sequencer and stencil-valid flagging for a linebuffer
//
// Purpose: counts pixel coordinates over an IMG_W x IMG_H frame, drives the
// linebuffer write enable, and marks outputs that carry a complete stencil
// window through a single-slot output register with valid/ready handshakes.
// Ports:
//   clk         in   clock
//   rst_n       in   synchronous active-low reset
//   start       in   begin a frame (sampled in IDLE only)
//   in_valid    in   upstream pixel present
//   in_ready    out  pixel accepted this cycle when in_valid
//   lb_wen      out  linebuffer write enable (== accept)
//   out_valid   out  window at out_col/out_row is complete
//   out_ready   in   downstream consumes the window
//   out_col     out  column of newest pixel in the window
//   out_row     out  row of newest pixel in the window
//   busy        out  frame in progress
//   frame_done  out  one-cycle pulse after the last window is consumed

module linebuffer_stream_ctrl
  import lb_ctrl_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int ST_W  = 3,
  parameter int ST_H  = 3,
  parameter int CW    = lb_width(IMG_W),
  parameter int RW    = lb_width(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          lb_wen,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_col,
  output logic [RW-1:0] out_row,
  output logic          busy,
  output logic          frame_done
);

  lb_state_e     state_q, state_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic [RW-1:0] out_row_q, out_row_d;

  logic [CW-1:0] cnt_col;
  logic [RW-1:0] cnt_row;
  logic          cnt_last;
  logic          cnt_clr;
  logic          running;
  logic          accept;
  logic          take;
  logic          col_ok;
  logic          row_ok;
  logic          win;

  lb_coord_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CW    (CW),
    .RW    (RW)
  ) u_coord (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .en_i   (accept),
    .col_o  (cnt_col),
    .row_o  (cnt_row),
    .last_o (cnt_last)
  );

  // A 1-wide stencil is complete on every column; skip the always-true compare.
  if (ST_W > 1) begin : g_col_ok
    assign col_ok = (cnt_col >= CW'(ST_W - 1));
  end else begin : g_col_all
    assign col_ok = 1'b1;
  end

  if (ST_H > 1) begin : g_row_ok
    assign row_ok = (cnt_row >= RW'(ST_H - 1));
  end else begin : g_row_all
    assign row_ok = 1'b1;
  end

  assign win     = col_ok && row_ok;
  assign running = (state_q == WARMUP) || (state_q == STREAM);

  // Single skid slot: accept a new pixel only if the held window leaves this cycle.
  assign in_ready   = running && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign take       = out_valid_q && out_ready;
  assign lb_wen     = accept;
  assign cnt_clr    = (state_q == IDLE) && start;

  assign out_valid  = out_valid_q;
  assign out_col    = out_col_q;
  assign out_row    = out_row_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

  // A fresh accept overwrites the slot, which also covers take-and-accept together.
  always_comb begin
    out_valid_d = out_valid_q;
    out_col_d   = out_col_q;
    out_row_d   = out_row_q;
    if (accept) begin
      out_valid_d = win;
      out_col_d   = cnt_col;
      out_row_d   = cnt_row;
    end else if (take) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = WARMUP;
      // The first complete window may also be the last pixel (stencil == frame).
      WARMUP:  if (accept && win) state_d = cnt_last ? DRAIN : STREAM;
      STREAM:  if (accept && cnt_last) state_d = DRAIN;
      DRAIN:   if (!out_valid_q || take) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
    end
  end

endmodule
